matrix_scan_ctrl: RTL and testbench

Column-multiplexed scan controller for the 5x7 LED dot matrix, which the 35-bit pattern decoders drive.
- Holds a double-buffered 35-bit frame and drives one column at a time, with a blanking gap between columns to prevent ghosting.
- Accepts new frames through a valid/ready handshake and swaps them in only at frame boundaries, so a partial frame is never displayed.

---
 rtl/matrix_pkg.sv | 31 +++
 rtl/frame_dbuf.sv | 47 ++++
 rtl/matrix_scan_ctrl.sv | 134 +++++++++++++
 tb/tb_matrix_scan_ctrl.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
`default_nettype none
// ============================================================================
// Module   : matrix_pkg
// Brief    : Shared geometry, scan state type and column slicing helper for
//            the 5x7 LED matrix scan controller.
// Revision : 1.0 - initial release
// ============================================================================
package matrix_pkg;

    localparam int N_COLS  = 5;
    localparam int N_ROWS  = 7;
    localparam int FRAME_W = 35;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_t;

    // Column c occupies frame[34-7c -: 7].
    function automatic logic [N_ROWS-1:0] col_slice(
        input logic [FRAME_W-1:0] frame,
        input logic [2:0]         idx
    );
        logic [FRAME_W-1:0] w_shift;
        w_shift = frame << (N_ROWS * int'(idx));
        return w_shift[FRAME_W-1 -: N_ROWS];
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_dbuf.sv
`default_nettype none
// ============================================================================
// Module   : frame_dbuf
// Brief    : Pending/active frame double buffer with valid/ready intake and a
//            swap that only happens at frame boundaries.
// Revision : 1.0 - initial release
// ============================================================================
module frame_dbuf
    import matrix_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [FRAME_W-1:0] i_frame,
    input  logic               i_valid,
    input  logic               i_swap,
    output logic               o_ready,
    output logic [FRAME_W-1:0] o_active
);

    logic [FRAME_W-1:0] r_pending;
    logic [FRAME_W-1:0] r_active;
    logic               r_pend_full;
    logic               w_xfer;

    assign w_xfer = i_valid && !r_pend_full;

    // A swap needs a full pending buffer, so it can never coincide with an
    // intake; a frame taken on a boundary edge waits for the next boundary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending   <= '0;
            r_active    <= '0;
            r_pend_full <= 1'b0;
        end else if (i_swap && r_pend_full) begin
            r_active    <= r_pending;
            r_pend_full <= 1'b0;
        end else if (w_xfer) begin
            r_pending   <= i_frame;
            r_pend_full <= 1'b1;
        end
    end

    assign o_ready  = !r_pend_full;
    assign o_active = r_active;

endmodule
`default_nettype wire

// File: rtl/matrix_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : matrix_scan_ctrl
// Brief    : Column-multiplexed 5x7 LED scan controller with blanking gap and
//            frame-boundary double buffering.
// Revision : 1.0 - initial release
// ============================================================================
module matrix_scan_ctrl
    import matrix_pkg::*;
#(
    parameter int CLK_DIV        = 50000,
    parameter int BLANK_CYC      = 4,
    parameter bit COL_ACTIVE_LOW = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [FRAME_W-1:0] frame_in,
    input  logic               frame_valid,
    output logic               frame_ready,
    output logic [N_COLS-1:0]  col,
    output logic [N_ROWS-1:0]  row,
    output logic               frame_done
);

    localparam int c_CNT_MAX = (CLK_DIV > BLANK_CYC) ? CLK_DIV : BLANK_CYC;
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;

    localparam logic [c_CNT_W-1:0] c_BLANK_LAST = c_CNT_W'(BLANK_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_DRIVE_LAST = c_CNT_W'(CLK_DIV - 1);
    localparam logic [2:0]         c_LAST_COL   = 3'(N_COLS - 1);
    localparam logic [N_COLS-1:0]  c_COL_IDLE   = {N_COLS{COL_ACTIVE_LOW}};
    localparam logic [N_COLS-1:0]  c_COL_ONE    = {{(N_COLS-1){1'b0}}, 1'b1};

    scan_state_t         r_state;
    scan_state_t         w_state_nxt;
    logic [2:0]          r_idx;
    logic [2:0]          w_idx_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CNT_W-1:0]  w_cnt_nxt;
    logic                w_swap;
    logic                w_wrap;
    logic [FRAME_W-1:0]  w_active;
    logic [N_COLS-1:0]   r_col;
    logic [N_COLS-1:0]   w_col_nxt;
    logic [N_ROWS-1:0]   r_row;
    logic [N_ROWS-1:0]   w_row_nxt;
    logic                r_frame_done;

    frame_dbuf u_dbuf (
        .clk      (clk),
        .reset    (reset),
        .i_frame  (frame_in),
        .i_valid  (frame_valid),
        .i_swap   (w_swap),
        .o_ready  (frame_ready),
        .o_active (w_active)
    );

    // Disable wins over every other transition, including the wrap edge.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_swap      = 1'b0;
        w_wrap      = 1'b0;
        if (!enable) begin
            w_state_nxt = IDLE;
            w_idx_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = BLANK;
                    w_idx_nxt   = '0;
                    w_swap      = 1'b1;
                end
                BLANK: begin
                    if (r_cnt == c_BLANK_LAST) begin
                        w_state_nxt = DRIVE;
                    end
                end
                DRIVE: begin
                    if (r_cnt == c_DRIVE_LAST) begin
                        w_state_nxt = BLANK;
                        if (r_idx == c_LAST_COL) begin
                            w_idx_nxt = '0;
                            w_swap    = 1'b1;
                            w_wrap    = 1'b1;
                        end else begin
                            w_idx_nxt = r_idx + 3'd1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_idx_nxt   = '0;
                end
            endcase
        end

        w_cnt_nxt = ((w_state_nxt != r_state) || (w_state_nxt == IDLE)) ? '0 : r_cnt + 1'b1;

        // Active frame only changes on BLANK entry, so it is stable here.
        w_col_nxt = c_COL_IDLE;
        w_row_nxt = '0;
        if (w_state_nxt == DRIVE) begin
            w_col_nxt = c_COL_IDLE ^ (c_COL_ONE << w_idx_nxt);
            w_row_nxt = col_slice(w_active, w_idx_nxt);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_col        <= c_COL_IDLE;
            r_row        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_cnt        <= w_cnt_nxt;
            r_col        <= w_col_nxt;
            r_row        <= w_row_nxt;
            r_frame_done <= w_wrap;
        end
    end

    assign col        = r_col;
    assign row        = r_row;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_matrix_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_scan_ctrl
// Brief    : Scenario bench for matrix_scan_ctrl against a cycle-position
//            reference model; active-high and active-low instances side by side.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_scan_ctrl;

    localparam int CLK_DIV   = 4;
    localparam int BLANK_CYC = 1;
    localparam int COLP      = CLK_DIV + BLANK_CYC;
    localparam int PERIOD    = 5 * COLP;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        frame_valid = 1'b0;
    logic [34:0] frame_in = '0;
    logic        frame_ready, frame_done, frame_ready_al, frame_done_al;
    logic [4:0]  col, col_al;
    logic [6:0]  row, row_al;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    matrix_scan_ctrl #(.CLK_DIV(CLK_DIV), .BLANK_CYC(BLANK_CYC), .COL_ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .reset(reset), .enable(enable), .frame_in(frame_in),
        .frame_valid(frame_valid), .frame_ready(frame_ready),
        .col(col), .row(row), .frame_done(frame_done)
    );

    matrix_scan_ctrl #(.CLK_DIV(CLK_DIV), .BLANK_CYC(BLANK_CYC), .COL_ACTIVE_LOW(1'b1)) dut_al (
        .clk(clk), .reset(reset), .enable(enable), .frame_in(frame_in),
        .frame_valid(frame_valid), .frame_ready(frame_ready_al),
        .col(col_al), .row(row_al), .frame_done(frame_done_al)
    );

    // Reference model: position within the scan is derived from the number of
    // cycles since the scan started, not from any state machine.
    bit          m_run = 1'b0;
    int          m_k = 0;
    logic [34:0] m_active = '0;
    logic [34:0] m_pending = '0;
    bit          m_pfull = 1'b0;
    int          m_xfers = 0;
    logic [4:0]  e_col = '0;
    logic [6:0]  e_row = '0;
    bit          e_done = 1'b0;

    function automatic logic [6:0] slice_of(input logic [34:0] f, input int c);
        logic [34:0] t;
        t = f >> (28 - 7 * c);
        return t[6:0];
    endfunction

    function automatic logic [34:0] rand_frame();
        return {3'($urandom), 32'($urandom)};
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_run = 1'b0; m_k = 0; m_active = '0; m_pending = '0; m_pfull = 1'b0;
            e_col = '0; e_row = '0; e_done = 1'b0;
        end else begin
            bit boundary;
            bit xfer;
            int q;
            boundary = 1'b0;
            e_done   = 1'b0;
            if (!enable) begin
                m_run = 1'b0; m_k = 0;
            end else if (!m_run) begin
                m_run = 1'b1; m_k = 1; boundary = 1'b1;
            end else begin
                m_k++;
                if ((m_k - 1) % PERIOD == 0) begin
                    boundary = 1'b1; e_done = 1'b1;
                end
            end
            xfer = frame_valid && !m_pfull;
            if (boundary && m_pfull) begin
                m_active = m_pending; m_pfull = 1'b0;
            end
            if (xfer) begin
                m_pending = frame_in; m_pfull = 1'b1; m_xfers++;
            end
            e_col = '0;
            e_row = '0;
            if (m_run) begin
                q = (m_k - 1) % PERIOD;
                if (q % COLP >= BLANK_CYC) begin
                    e_col = 5'(1 << (q / COLP));
                    e_row = slice_of(m_active, q / COLP);
                end
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++;
        if ({col, row, frame_done, frame_ready} !== {5'b00000, 7'h00, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_init got col=%b row=%h done=%b rdy=%b exp 00000/00/0/1", col, row, frame_done, frame_ready);
        end
        checks++;
        if ({col_al, row_al, frame_done_al, frame_ready_al} !== {5'b11111, 7'h00, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_init_al got col=%b row=%h done=%b rdy=%b exp 11111/00/0/1", col_al, row_al, frame_done_al, frame_ready_al);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset  = 1'b0;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (col !== 5'b00001) begin
            errors++;
            $display("FAIL pre_reset_drive got col=%b exp 00001", col);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({col, row, frame_done, frame_ready} !== {5'b00000, 7'h00, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_async got col=%b row=%h done=%b rdy=%b exp 00000/00/0/1", col, row, frame_done, frame_ready);
        end
        checks++;
        if (col_al !== 5'b11111) begin
            errors++;
            $display("FAIL reset_async_al got col=%b exp 11111", col_al);
        end
        enable = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_scan();
        int dones;
        dones       = 0;
        frame_in    = 35'h7_F000_0001;
        frame_valid = 1'b1;
        @(negedge clk);
        frame_valid = 1'b0;
        enable      = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            checks++;
            if ({col, row, frame_done, frame_ready} !== {e_col, e_row, e_done, !m_pfull}) begin
                errors++;
                $display("FAIL scan k=%0d got col=%b row=%h done=%b rdy=%b exp col=%b row=%h done=%b rdy=%b",
                         m_k, col, row, frame_done, frame_ready, e_col, e_row, e_done, !m_pfull);
            end
            checks++;
            if ({col_al, row_al, frame_done_al} !== {~e_col, e_row, e_done}) begin
                errors++;
                $display("FAIL scan_al k=%0d got col=%b row=%h done=%b exp col=%b row=%h done=%b",
                         m_k, col_al, row_al, frame_done_al, ~e_col, e_row, e_done);
            end
            if (frame_done) dones++;
            if (i == 2) begin
                checks++;
                if ({col, row, col_al} !== {5'b00001, 7'h7F, 5'b11110}) begin
                    errors++;
                    $display("FAIL scan_col0 got col=%b row=%h col_al=%b exp 00001/7f/11110", col, row, col_al);
                end
            end
            if (i == 12) begin
                checks++;
                if ({col, row} !== {5'b00100, 7'h00}) begin
                    errors++;
                    $display("FAIL scan_col2 got col=%b row=%h exp 00100/00", col, row);
                end
            end
            if (i == 22) begin
                checks++;
                if ({col, row} !== {5'b10000, 7'h01}) begin
                    errors++;
                    $display("FAIL scan_col4 got col=%b row=%h exp 10000/01", col, row);
                end
            end
            if (i == 26) begin
                checks++;
                if (frame_done !== 1'b1) begin
                    errors++;
                    $display("FAIL scan_done_c26 got %b exp 1", frame_done);
                end
            end
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL scan_done_count got %0d exp 1", dones);
        end
    endtask

    task automatic test_back_to_back();
        logic [34:0] fr [3];
        int n;
        bit took;
        for (int i = 0; i < 3; i++) fr[i] = rand_frame();
        n           = 0;
        took        = 1'b0;
        frame_in    = fr[0];
        frame_valid = 1'b1;
        for (int cyc = 0; cyc < 4 * PERIOD; cyc++) begin
            @(negedge clk);
            checks++;
            if ({col, row, frame_done, frame_ready} !== {e_col, e_row, e_done, !m_pfull}) begin
                errors++;
                $display("FAIL b2b k=%0d got col=%b row=%h done=%b rdy=%b exp col=%b row=%h done=%b rdy=%b",
                         m_k, col, row, frame_done, frame_ready, e_col, e_row, e_done, !m_pfull);
            end
            if (took) begin
                n++;
                if (n < 3) frame_in = fr[n];
                else frame_valid = 1'b0;
            end
            took = frame_valid && frame_ready;
        end
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL b2b_accepted got %0d exp 3", n);
        end
    endtask

    task automatic test_boundary_offer();
        logic [34:0] f;
        logic [34:0] old;
        int cyc;
        int dones;
        f   = rand_frame();
        cyc = 0;
        while (!(!m_pfull && m_run && (m_k % PERIOD) == 0) && cyc < 3 * PERIOD) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 3 * PERIOD) begin
            checks++; errors++;
            $display("FAIL boundary_wait got timeout exp wrap with empty pending");
        end
        old         = m_active;
        frame_in    = f;
        frame_valid = 1'b1;
        dones       = 0;
        for (int i = 1; i <= 2 * PERIOD + 2; i++) begin
            @(negedge clk);
            frame_valid = 1'b0;
            checks++;
            if ({col, row, frame_done, frame_ready} !== {e_col, e_row, e_done, !m_pfull}) begin
                errors++;
                $display("FAIL bnd k=%0d got col=%b row=%h done=%b rdy=%b exp col=%b row=%h done=%b rdy=%b",
                         m_k, col, row, frame_done, frame_ready, e_col, e_row, e_done, !m_pfull);
            end
            if (i <= PERIOD && frame_done) dones++;
            if (i == 1) begin
                checks++;
                if ({frame_done, frame_ready} !== 2'b10) begin
                    errors++;
                    $display("FAIL bnd_edge got done=%b rdy=%b exp done=1 rdy=0", frame_done, frame_ready);
                end
            end
            if (i == 2) begin
                checks++;
                if (row !== slice_of(old, 0)) begin
                    errors++;
                    $display("FAIL bnd_old_frame got row=%h exp %h", row, slice_of(old, 0));
                end
            end
            if (i == PERIOD + 2) begin
                checks++;
                if (row !== slice_of(f, 0)) begin
                    errors++;
                    $display("FAIL bnd_new_frame got row=%h exp %h", row, slice_of(f, 0));
                end
            end
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL bnd_done_count got %0d exp 1", dones);
        end
    endtask

    task automatic test_disable();
        logic [34:0] x;
        int cyc;
        x   = rand_frame();
        cyc = 0;
        while (!(m_run && !m_pfull && ((m_k - 1) % PERIOD) / COLP == 1) && cyc < 2 * PERIOD) begin
            @(negedge clk);
            cyc++;
        end
        frame_in    = x;
        frame_valid = 1'b1;
        @(negedge clk);
        frame_valid = 1'b0;
        while (((m_k - 1) % PERIOD) != 2 * COLP + BLANK_CYC && cyc < 2 * PERIOD) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 2 * PERIOD) begin
            checks++; errors++;
            $display("FAIL dis_wait got timeout exp column 2 drive");
        end
        enable = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            checks++;
            if ({col, row, frame_done, frame_ready, col_al} !== {5'b00000, 7'h00, 1'b0, 1'b0, 5'b11111}) begin
                errors++;
                $display("FAIL dis_off i=%0d got col=%b row=%h done=%b rdy=%b col_al=%b exp 00000/00/0/0/11111",
                         i, col, row, frame_done, frame_ready, col_al);
            end
        end
        enable = 1'b1;
        for (int i = 1; i <= PERIOD + 2; i++) begin
            @(negedge clk);
            checks++;
            if ({col, row, frame_done, frame_ready} !== {e_col, e_row, e_done, !m_pfull}) begin
                errors++;
                $display("FAIL dis_re k=%0d got col=%b row=%h done=%b rdy=%b exp col=%b row=%h done=%b rdy=%b",
                         m_k, col, row, frame_done, frame_ready, e_col, e_row, e_done, !m_pfull);
            end
            if (i == 2) begin
                checks++;
                if ({col, row, frame_ready} !== {5'b00001, slice_of(x, 0), 1'b1}) begin
                    errors++;
                    $display("FAIL dis_restart got col=%b row=%h rdy=%b exp 00001/%h/1", col, row, frame_ready, slice_of(x, 0));
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 700; i++) begin
            if (enable) begin
                if ($urandom_range(0, 99) < 1) enable = 1'b0;
            end else if ($urandom_range(0, 9) < 3) begin
                enable = 1'b1;
            end
            frame_valid = ($urandom_range(0, 3) == 0);
            frame_in    = rand_frame();
            @(negedge clk);
            checks++;
            if ({col, row, frame_done, frame_ready} !== {e_col, e_row, e_done, !m_pfull}) begin
                errors++;
                $display("FAIL rand k=%0d got col=%b row=%h done=%b rdy=%b exp col=%b row=%h done=%b rdy=%b",
                         m_k, col, row, frame_done, frame_ready, e_col, e_row, e_done, !m_pfull);
            end
            checks++;
            if ({col_al, row_al, frame_done_al, frame_ready_al} !== {~e_col, e_row, e_done, !m_pfull}) begin
                errors++;
                $display("FAIL rand_al k=%0d got col=%b row=%h done=%b rdy=%b exp col=%b row=%h done=%b rdy=%b",
                         m_k, col_al, row_al, frame_done_al, frame_ready_al, ~e_col, e_row, e_done, !m_pfull);
            end
        end
        frame_valid = 1'b0;
    endtask

    initial begin
        #1;
        test_reset();
        test_scan();
        test_back_to_back();
        test_boundary_offer();
        test_disable();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got no finish exp finish before 1ms");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
